// File: rtl/fec_pkg.sv
// Shared uplink FEC types and encoder geometry constants.
// ENC1 describes the header (message-ID) words, ENC0 the payload words.
package fec_pkg;

  localparam int unsigned ENC1_WIDTH = 8;
  localparam int unsigned ENC1_DEPTH = 4;
  localparam int unsigned ENC0_WIDTH = 8;
  localparam int unsigned ENC0_DEPTH = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TRAIN_START,
    S_TRAIN_WAIT,
    S_HDR_START,
    S_HDR_WAIT,
    S_FEC_WAIT,
    S_DATA_START,
    S_DATA_WAIT,
    S_LOCKOUT
  } ul_frame_state_t;

  typedef enum logic {PH_HDR, PH_DATA} ul_phase_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ul_wdog_timer.sv
// Phase watchdog: cleared by load, counts while enabled, flags when it reaches a nonzero limit.
module ul_wdog_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (limit != '0) && (count == limit);

endmodule

// File: rtl/ul_frame_ctrl.sv
// Uplink frame sequencer: training -> header deser -> FEC decode -> payload chunks,
// with per-phase watchdog, consecutive-error lockout and saturating statistics.
module ul_frame_ctrl
  import fec_pkg::*;
#(
  parameter int unsigned SERIAL_DIV_WIDTH = 8,
  parameter int unsigned HDR_WIDTH        = ENC1_WIDTH,
  parameter int unsigned HDR_DEPTH        = ENC1_DEPTH,
  parameter int unsigned DATA_WIDTH       = ENC0_WIDTH,
  parameter int unsigned DATA_DEPTH       = ENC0_DEPTH,
  parameter int unsigned LEN_WIDTH        = 8,
  parameter int unsigned TMO_WIDTH        = 16,
  parameter int unsigned ERR_WIDTH        = 4,
  parameter int unsigned STAT_WIDTH       = 16,
  localparam int unsigned DW_W = $clog2(max2(HDR_WIDTH, DATA_WIDTH)) + 1,
  localparam int unsigned DD_W = $clog2(max2(HDR_DEPTH, DATA_DEPTH)) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ul_en,
  input  logic [SERIAL_DIV_WIDTH-1:0] cfg_clk_div,
  input  logic [TMO_WIDTH-1:0]        cfg_timeout,
  input  logic [ERR_WIDTH-1:0]        cfg_max_err,
  input  logic                        clear_lock,
  output logic [SERIAL_DIV_WIDTH-1:0] clk_div,
  output logic                        training_start,
  input  logic                        training_done,
  output logic                        deser_start,
  input  logic                        deser_done,
  output logic [DW_W-1:0]             deser_width,
  output logic [DD_W-1:0]             deser_depth,
  input  logic                        fec_done,
  input  logic                        fec_uncor_err,
  input  logic [LEN_WIDTH-1:0]        fec_msg_len,
  output logic                        frame_ok,
  output logic                        frame_err,
  output logic                        locked,
  output logic                        busy,
  output logic [STAT_WIDTH-1:0]       stat_ok,
  output logic [STAT_WIDTH-1:0]       stat_err
);

  ul_frame_state_t      state;
  ul_phase_t            next_ph;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH:0]   byte_cnt;
  logic [LEN_WIDTH:0]   byte_nxt;
  logic [ERR_WIDTH-1:0] err_cnt;
  logic [ERR_WIDTH-1:0] err_nxt;
  logic                 lock_hit;
  logic                 in_wait;
  logic                 wd_load;
  logic                 expired;
  logic                 ev_ok;
  logic                 ev_err;

  assign clk_div = cfg_clk_div;
  assign locked  = (state == S_LOCKOUT);
  assign busy    = (state != S_IDLE) && (state != S_LOCKOUT);

  assign byte_nxt = byte_cnt + (LEN_WIDTH+1)'(DATA_DEPTH);
  assign err_nxt  = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
  assign lock_hit = (cfg_max_err != '0) && (err_nxt >= cfg_max_err);

  assign in_wait = (state == S_TRAIN_WAIT) || (state == S_HDR_WAIT) ||
                   (state == S_FEC_WAIT)   || (state == S_DATA_WAIT);
  // Every WAIT is entered from a non-WAIT state except FEC_WAIT, which follows HDR_WAIT.
  assign wd_load = !in_wait || ((state == S_HDR_WAIT) && deser_done);

  ul_wdog_timer #(.WIDTH(TMO_WIDTH)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .enable (in_wait),
    .limit  (cfg_timeout),
    .expired(expired)
  );

  // Frame-level events; a done input beats a same-cycle timeout, ul_en loss beats both.
  always_comb begin
    ev_ok  = 1'b0;
    ev_err = 1'b0;
    if (ul_en) begin
      case (state)
        S_TRAIN_WAIT: ev_err = !training_done && expired;
        S_HDR_WAIT:   ev_err = !deser_done && expired;
        S_FEC_WAIT: begin
          ev_err = fec_done ? fec_uncor_err : expired;
          ev_ok  = fec_done && !fec_uncor_err && (fec_msg_len == '0);
        end
        S_DATA_WAIT: begin
          ev_err = !deser_done && expired;
          ev_ok  = deser_done && (byte_nxt >= {1'b0, len});
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      next_ph        <= PH_HDR;
      len            <= '0;
      byte_cnt       <= '0;
      err_cnt        <= '0;
      training_start <= 1'b0;
      deser_start    <= 1'b0;
      frame_ok       <= 1'b0;
      frame_err      <= 1'b0;
      deser_width    <= DW_W'(HDR_WIDTH - 1);
      deser_depth    <= DD_W'(HDR_DEPTH - 1);
      stat_ok        <= '0;
      stat_err       <= '0;
    end else begin
      training_start <= 1'b0;
      deser_start    <= 1'b0;
      frame_ok       <= 1'b0;
      frame_err      <= 1'b0;
      if (!ul_en && (state != S_LOCKOUT)) begin
        state   <= S_IDLE;
        next_ph <= PH_HDR;
      end else begin
        case (state)
          S_IDLE:        state <= S_TRAIN_START;
          S_TRAIN_START: begin
            training_start <= 1'b1;
            state          <= S_TRAIN_WAIT;
          end
          S_TRAIN_WAIT:
            if (training_done) state <= (next_ph == PH_HDR) ? S_HDR_START : S_DATA_START;
          S_HDR_START: begin
            deser_start <= 1'b1;
            deser_width <= DW_W'(HDR_WIDTH - 1);
            deser_depth <= DD_W'(HDR_DEPTH - 1);
            state       <= S_HDR_WAIT;
          end
          S_HDR_WAIT:
            if (deser_done) state <= S_FEC_WAIT;
          S_FEC_WAIT:
            if (fec_done && !fec_uncor_err) begin
              len      <= fec_msg_len;
              byte_cnt <= '0;
              next_ph  <= (fec_msg_len == '0) ? PH_HDR : PH_DATA;
              state    <= S_TRAIN_START;
            end
          S_DATA_START: begin
            deser_start <= 1'b1;
            deser_width <= DW_W'(DATA_WIDTH - 1);
            deser_depth <= DD_W'(DATA_DEPTH - 1);
            state       <= S_DATA_WAIT;
          end
          S_DATA_WAIT:
            if (deser_done) begin
              byte_cnt <= byte_nxt;
              state    <= S_TRAIN_START;
            end
          S_LOCKOUT:
            if (clear_lock) begin
              state   <= S_IDLE;
              err_cnt <= '0;
              next_ph <= PH_HDR;
            end
          default: state <= S_IDLE;
        endcase

        if (ev_ok) begin
          frame_ok <= 1'b1;
          err_cnt  <= '0;
          next_ph  <= PH_HDR;
          if (stat_ok != '1) stat_ok <= stat_ok + 1'b1;
        end
        if (ev_err) begin
          frame_err <= 1'b1;
          err_cnt   <= err_nxt;
          next_ph   <= PH_HDR;
          state     <= lock_hit ? S_LOCKOUT : S_TRAIN_START;
          if (stat_err != '1) stat_err <= stat_err + 1'b1;
        end
      end
    end
  end

endmodule
